// File: rtl/button_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_pulse_conditioner
// Purpose  : Synchronises and debounces the calculator's Enter and Undo push
//            buttons and emits one single-cycle pulse per accepted press.
//            Enter wins when both channels would pulse at the same edge; the
//            Undo pulse for that edge is dropped.
// Ports    : clock          - system clock, rising edge
//            reset          - asynchronous, active-high reset
//            btn_enter_raw  - raw Enter button (asynchronous, bouncy)
//            btn_undo_raw   - raw Undo button (asynchronous, bouncy)
//            Enter_pulse    - one-cycle pulse per accepted Enter press
//            Undo_pulse     - one-cycle pulse per accepted Undo press
//            enter_level    - debounced Enter level (registered)
//            undo_level     - debounced Undo level (registered)
// Params   : DEBOUNCE_CYCLES - cycles a new level must persist (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_enter_raw,
    input  logic btn_undo_raw,
    output logic Enter_pulse,
    output logic Undo_pulse,
    output logic enter_level,
    output logic undo_level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is Enter, channel 1 is Undo.
    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_level;

    assign w_raw = {btn_undo_raw, btn_enter_raw};

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_chan
            logic             s1_q;
            logic             s2_q;
            logic             stable_q;
            logic             stable_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    s1_q     <= w_raw[ch];
                    s2_q     <= s1_q;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            // The counter only advances while the synchronised input disagrees
            // with the accepted level; any agreeing cycle clears it, so a new
            // level is taken only after DEBOUNCE_CYCLES uninterrupted cycles.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (s2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Rising transition of the accepted level, seen at the same edge
            // that updates stable_q, so the pulse register lines up with it.
            assign w_rise[ch]  = stable_d & ~stable_q;
            assign w_level[ch] = stable_q;
        end
    endgenerate

    logic enter_pulse_q;
    logic enter_pulse_d;
    logic undo_pulse_q;
    logic undo_pulse_d;

    // Enter has priority; a coincident Undo press is lost, not deferred.
    always_comb begin
        enter_pulse_d = w_rise[0];
        undo_pulse_d  = w_rise[1] & ~w_rise[0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_pulse_q <= 1'b0;
            undo_pulse_q  <= 1'b0;
        end else begin
            enter_pulse_q <= enter_pulse_d;
            undo_pulse_q  <= undo_pulse_d;
        end
    end

    assign Enter_pulse = enter_pulse_q;
    assign Undo_pulse  = undo_pulse_q;
    assign enter_level = w_level[0];
    assign undo_level  = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_pulse_conditioner
// Purpose  : Self-checking bench for button_pulse_conditioner with
//            DEBOUNCE_CYCLES = 4. A reference model predicts the outputs after
//            every clock edge and queues them; a monitor pops and compares on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_pulse_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic be  = 1'b0;
    logic bu  = 1'b0;
    logic Enter_pulse;
    logic Undo_pulse;
    logic enter_level;
    logic undo_level;

    button_pulse_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock         (clk),
        .reset         (rst),
        .btn_enter_raw (be),
        .btn_undo_raw  (bu),
        .Enter_pulse   (Enter_pulse),
        .Undo_pulse    (Undo_pulse),
        .enter_level   (enter_level),
        .undo_level    (undo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ep;
        logic up;
        logic el;
        logic ul;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int dut_ep   = 0;
    int dut_up   = 0;

    // ------------------------------------------------------------------
    // Reference model: raw samples pass through a two-sample delay, the
    // delayed samples are kept in a sliding window of the last D values, and
    // a channel's level flips when every sample in the window is the
    // opposite of its current level. Bit 0 = Enter, bit 1 = Undo.
    // ------------------------------------------------------------------
    logic [1:0] m_h0 = '0;
    logic [1:0] m_h1 = '0;
    logic [1:0] m_lvl = '0;
    logic [1:0] m_win[$];

    task automatic model_reset();
        m_h0  = '0;
        m_h1  = '0;
        m_lvl = '0;
        m_win.delete();
    endtask

    task automatic model_edge(input logic e, input logic u);
        logic [1:0] dly;
        logic [1:0] acc;
        logic [1:0] rise;
        exp_t       x;
        dly  = m_h1;
        m_h1 = m_h0;
        m_h0 = {u, e};
        m_win.push_back(dly);
        if (m_win.size() > D) void'(m_win.pop_front());
        rise = '0;
        for (int ch = 0; ch < 2; ch++) begin
            acc[ch] = (m_win.size() == D);
            foreach (m_win[i]) if (m_win[i][ch] == m_lvl[ch]) acc[ch] = 1'b0;
            if (acc[ch]) begin
                m_lvl[ch] = ~m_lvl[ch];
                rise[ch]  = m_lvl[ch];
            end
        end
        x.ep = rise[0];
        x.up = rise[1] & ~rise[0];
        x.el = m_lvl[0];
        x.ul = m_lvl[1];
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b time=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (Enter_pulse === 1'b1) dut_ep++;
            if (Undo_pulse === 1'b1) dut_up++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("Enter_pulse", Enter_pulse, x.ep);
                chk("Undo_pulse",  Undo_pulse,  x.up);
                chk("enter_level", enter_level, x.el);
                chk("undo_level",  undo_level,  x.ul);
                chk("pulses_exclusive", Enter_pulse & Undo_pulse, 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic e, input logic u);
        be = e;
        bu = u;
        @(posedge clk);
        model_edge(e, u);
        #1;
    endtask

    task automatic steps(input logic e, input logic u, input int n);
        for (int i = 0; i < n; i++) step(e, u);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_Enter_pulse"}, Enter_pulse, 1'b0);
        chk({tag, "_Undo_pulse"},  Undo_pulse,  1'b0);
        chk({tag, "_enter_level"}, enter_level, 1'b0);
        chk({tag, "_undo_level"},  undo_level,  1'b0);
    endtask

    task automatic reset_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_reset();
            exp_q.push_back('0);
        end
        #2;
        rst = 1'b0;
    endtask

    // Asserts reset mid-cycle, away from any clock edge.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        reset_edges(2);
    endtask

    task automatic count_check(input string tag, input int base_e, input int base_u,
                               input int req_e, input int req_u);
        @(negedge clk);
        #1;
        chk_int({tag, "_enter_pulses"}, dut_ep - base_e, req_e);
        chk_int({tag, "_undo_pulses"},  dut_up - base_u, req_u);
    endtask

    initial begin
        int be0;
        int bu0;
        int rem_e;
        int rem_u;
        logic re;
        logic ru;

        #1;
        check_zero("reset_state");
        reset_edges(2);

        // Clean press and release on Enter
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b0, 1'b0, 8);
        steps(1'b1, 1'b0, 12);
        steps(1'b0, 1'b0, 12);
        count_check("clean_press", be0, bu0, 1, 0);

        // Bouncy Undo press
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b0, 1'b1, 3);
        step(1'b0, 1'b0);
        steps(1'b0, 1'b1, 2);
        step(1'b0, 1'b0);
        steps(1'b0, 1'b1, 12);
        steps(1'b0, 1'b0, 12);
        count_check("bounce", be0, bu0, 0, 1);

        // Long hold, release, press again
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b1, 1'b0, 50);
        steps(1'b0, 1'b0, 12);
        steps(1'b1, 1'b0, 12);
        steps(1'b0, 1'b0, 12);
        count_check("hold_release", be0, bu0, 2, 0);

        // Simultaneous press: Undo pulse is dropped
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b1, 1'b1, 12);
        chk("simul_enter_level", enter_level, 1'b1);
        chk("simul_undo_level",  undo_level,  1'b1);
        steps(1'b0, 1'b0, 12);
        count_check("simultaneous", be0, bu0, 1, 0);

        // Reset two cycles into the count with Enter held through it
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b1, 1'b0, 4);
        mid_reset("mid_reset");
        steps(1'b1, 1'b0, 12);
        steps(1'b0, 1'b0, 12);
        count_check("reset_mid_count", be0, bu0, 1, 0);

        // Sub-threshold glitch on Undo
        be0 = dut_ep; bu0 = dut_up;
        steps(1'b0, 1'b1, 3);
        steps(1'b0, 1'b0, 12);
        count_check("glitch", be0, bu0, 0, 0);

        // Random bouncing on both channels, with an occasional reset
        re = 1'b0; ru = 1'b0; rem_e = 0; rem_u = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rem_e == 0) begin re = ~re; rem_e = $urandom_range(1, 9); end
            if (rem_u == 0) begin ru = ~ru; rem_u = $urandom_range(1, 9); end
            step(re, ru);
            rem_e--;
            rem_u--;
            if (i == 1000) mid_reset("rand_reset");
        end
        steps(1'b0, 1'b0, 12);

        @(negedge clk);
        #1;
        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
